bus_host_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream bus-host port among NrHosts requesters, e.g. core data, debug SBA and a future DMA, in front of one host slot of the system bus.
- Uses the Ibex-style req/gnt/rvalid protocol on both sides.
- Tracks granted transactions in an ID FIFO so in-order responses (rvalid/rdata/err) are routed back to the host that issued them.
- Supports up to MaxOutstanding transactions in flight.

---
 rtl/bus_arb_pkg.sv | 20 ++
 rtl/bus_host_arbiter_if.sv | 43 ++++
 rtl/bus_arb_id_fifo.sv | 67 ++++++
 rtl/bus_host_arbiter.sv | 112 +++++++++++
 tb/tb_bus_host_arbiter.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus host arbiter slice.
package bus_arb_pkg;

  localparam int unsigned MaxHosts = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic            we;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   wdata;
  } host_req_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_host_arbiter_if.sv
// Upstream host ports plus the single downstream bus-host port of the arbiter.
interface bus_host_arbiter_if #(
  parameter int unsigned NrHosts      = 2,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
);
  // req/gnt/rvalid: a requester holds req and its fields stable until the
  // cycle req & gnt are both high; every granted transaction later gets
  // exactly one rvalid pulse (with rdata/err), strictly in grant order.
  logic [NrHosts-1:0]                   host_req_i;
  logic [NrHosts-1:0]                   host_gnt_o;
  logic [NrHosts-1:0][AddressWidth-1:0] host_addr_i;
  logic [NrHosts-1:0]                   host_we_i;
  logic [NrHosts-1:0][DataWidth/8-1:0]  host_be_i;
  logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i;
  logic [NrHosts-1:0]                   host_rvalid_o;
  logic [NrHosts-1:0][DataWidth-1:0]    host_rdata_o;
  logic [NrHosts-1:0]                   host_err_o;

  logic                    out_req_o;
  logic                    out_gnt_i;
  logic [AddressWidth-1:0] out_addr_o;
  logic                    out_we_o;
  logic [DataWidth/8-1:0]  out_be_o;
  logic [DataWidth-1:0]    out_wdata_o;
  logic                    out_rvalid_i;
  logic [DataWidth-1:0]    out_rdata_i;
  logic                    out_err_i;

  modport master (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output out_req_o, out_addr_o, out_we_o, out_be_o, out_wdata_o,
    input  out_gnt_i, out_rvalid_i, out_rdata_i, out_err_i
  );

  modport slave (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  out_req_o, out_addr_o, out_we_o, out_be_o, out_wdata_o,
    output out_gnt_i, out_rvalid_i, out_rdata_i, out_err_i
  );
endinterface

// File: rtl/bus_arb_id_fifo.sv
// FIFO of granted host indices; the head names the owner of the next response.
module bus_arb_id_fifo
  import bus_arb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned IdW   = 1,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [IdW-1:0]  push_id_i,
  input  logic            pop_i,
  output logic [IdW-1:0]  head_id_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);
  localparam int unsigned PtrW = idx_width(Depth);

  logic [IdW-1:0]  mem_q [Depth];
  logic [IdW-1:0]  mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_eff, pop_eff;

  assign full_o    = (count_q == CntW'(Depth));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign head_id_o = mem_q[rd_ptr_q];

  always_comb begin
    push_eff = push_i & ~full_o;
    pop_eff  = pop_i & ~empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_eff) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid bus-host port among NrHosts
// requesters, routing in-order responses back via an ID FIFO.
module bus_host_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  bus_host_arbiter_if.master bus,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o
);
  localparam int unsigned IdxW = idx_width(NrHosts);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] prio_q, prio_d, lock_id_q, lock_id_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] sel_rr, sel, head_id;
  logic            found, any_req, out_req, hs, pop;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

  // First requester at or after prio_q, wrapping around.
  always_comb begin
    sel_rr = prio_q;
    found  = 1'b0;
    for (int i = 0; i < int'(NrHosts); i++) begin
      int j;
      j = int'(prio_q) + i;
      if (j >= int'(NrHosts)) j = j - int'(NrHosts);
      if (!found && bus.host_req_i[j]) begin
        sel_rr = IdxW'(j);
        found  = 1'b1;
      end
    end
  end

  assign sel     = lock_q ? lock_id_q : sel_rr;
  assign any_req = |bus.host_req_i;
  assign out_req = (lock_q | any_req) & ~fifo_full;
  assign hs      = out_req & bus.out_gnt_i;
  assign pop     = bus.out_rvalid_i & ~fifo_empty;

  assign bus.out_req_o   = out_req;
  assign bus.out_addr_o  = bus.host_addr_i[sel];
  assign bus.out_we_o    = bus.host_we_i[sel];
  assign bus.out_be_o    = bus.host_be_i[sel];
  assign bus.out_wdata_o = bus.host_wdata_i[sel];

  assign bus.host_gnt_o    = hs ? (NrHosts'(1) << sel) : '0;
  assign bus.host_rvalid_o = pop ? (NrHosts'(1) << head_id) : '0;
  assign bus.host_err_o    = (pop & bus.out_err_i) ? (NrHosts'(1) << head_id) : '0;

  always_comb begin
    for (int h = 0; h < int'(NrHosts); h++) bus.host_rdata_o[h] = bus.out_rdata_i;
  end

  // A stalled request pins the selection; a full FIFO leaves lock untouched.
  always_comb begin
    prio_d    = prio_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (hs) begin
      lock_d = 1'b0;
      prio_d = (sel == IdxW'(NrHosts - 1)) ? '0 : sel + IdxW'(1);
    end else if (out_req) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      prio_q    <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  bus_arb_id_fifo #(
    .Depth(MaxOutstanding),
    .IdW  (IdxW),
    .CntW (CntW)
  ) u_id_fifo (
    .clk_i    (clk_sys_i),
    .rst_ni   (rst_sys_ni),
    .push_i   (hs),
    .push_id_i(sel),
    .pop_i    (pop),
    .head_id_o(head_id),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign outstanding_o = fifo_count;

  always @(posedge clk_sys_i) begin
    if (rst_sys_ni) begin
      assert (!(bus.out_rvalid_i && fifo_empty))
        else $warning("out_rvalid_i with no transaction outstanding, ignored");
    end
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed table-driven bench for bus_host_arbiter with two hosts, depth two.
module tb_bus_host_arbiter;
  import bus_arb_pkg::*;

  localparam int unsigned NH = 2;

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic        exp_oreq;
    int          exp_sel;
    logic [1:0]  exp_hgnt;
    logic [1:0]  exp_hrv;
    logic [1:0]  exp_herr;
    int          exp_cnt;
  } vec_t;

  logic       clk_sys_i;
  logic       rst_sys_ni;
  logic [1:0] outstanding_o;

  bus_host_arbiter_if #(.NrHosts(NH), .DataWidth(32), .AddressWidth(32)) bif ();

  bus_host_arbiter #(
    .NrHosts(NH), .DataWidth(32), .AddressWidth(32), .MaxOutstanding(2)
  ) dut (
    .clk_sys_i    (clk_sys_i),
    .rst_sys_ni   (rst_sys_ni),
    .bus          (bif.master),
    .outstanding_o(outstanding_o)
  );

  // clock / reset
  initial clk_sys_i = 1'b0;
  always #5 clk_sys_i = ~clk_sys_i;

  int        errors = 0;
  int        checks = 0;
  int        cur_row = 0;
  host_req_t host_cfg [NH];
  vec_t      tbl [$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d act=%0h exp=%0h", name, cur_row, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic err);
    bif.host_req_i   = req;
    bif.out_gnt_i    = gnt;
    bif.out_rvalid_i = rv;
    bif.out_rdata_i  = rdata;
    bif.out_err_i    = err;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk_sys_i);
    drive(v.req, v.gnt, v.rv, v.rdata, v.err);
    #1;
    check("out_req", 96'(bif.out_req_o), 96'(v.exp_oreq));
    check("host_gnt", 96'(bif.host_gnt_o), 96'(v.exp_hgnt));
    check("host_rvalid", 96'(bif.host_rvalid_o), 96'(v.exp_hrv));
    check("host_err", 96'(bif.host_err_o & bif.host_rvalid_o), 96'(v.exp_herr));
    check("outstanding", 96'(outstanding_o), 96'(v.exp_cnt));
    if (v.exp_oreq) begin
      check("out_fields", 96'({bif.out_addr_o, bif.out_we_o, bif.out_be_o, bif.out_wdata_o}),
            96'(host_cfg[v.exp_sel]));
    end
    if (v.rv) begin
      check("rdata_h0", 96'(bif.host_rdata_o[0]), 96'(v.rdata));
      check("rdata_h1", 96'(bif.host_rdata_o[1]), 96'(v.rdata));
    end
    cur_row++;
  endtask

  initial begin
    host_cfg[0] = '{addr: 32'h0010_0000, we: 1'b1, be: 4'hF, wdata: 32'hA0A0_0001};
    host_cfg[1] = '{addr: 32'h8000_0000, we: 1'b0, be: 4'h3, wdata: 32'hB1B1_0002};
    for (int h = 0; h < int'(NH); h++) begin
      bif.host_addr_i[h]  = host_cfg[h].addr;
      bif.host_we_i[h]    = host_cfg[h].we;
      bif.host_be_i[h]    = host_cfg[h].be;
      bif.host_wdata_i[h] = host_cfg[h].wdata;
    end
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_sys_ni = 1'b0;

    //           req    gnt  rv   rdata          err  oreq sel hgnt   hrv    herr   cnt
    tbl.push_back('{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 0, 2'b00, 2'b00, 2'b00, 0}); // idle
    tbl.push_back('{2'b10, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1, 2'b10, 2'b00, 2'b00, 0}); // single req h1
    tbl.push_back('{2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 0, 2'b00, 2'b10, 2'b00, 1}); // resp to h1
    tbl.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 0, 2'b01, 2'b00, 2'b00, 0}); // rr: 0
    tbl.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1, 2'b10, 2'b00, 2'b00, 1}); // rr: 1
    tbl.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 0, 2'b00, 2'b00, 2'b00, 2}); // full
    tbl.push_back('{2'b11, 1'b1, 1'b1, 32'h11,       1'b0, 1'b0, 0, 2'b00, 2'b01, 2'b00, 2}); // full + pop
    tbl.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 0, 2'b01, 2'b00, 2'b00, 1}); // regrant 0
    tbl.push_back('{2'b00, 1'b0, 1'b1, 32'h22,       1'b1, 1'b0, 0, 2'b00, 2'b10, 2'b10, 2}); // resp h1 err
    tbl.push_back('{2'b00, 1'b0, 1'b1, 32'h33,       1'b0, 1'b0, 0, 2'b00, 2'b01, 2'b00, 1}); // resp h0
    tbl.push_back('{2'b10, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1, 2'b00, 2'b00, 2'b00, 0}); // stall h1
    tbl.push_back('{2'b11, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1, 2'b00, 2'b00, 2'b00, 0}); // h0 joins
    tbl.push_back('{2'b11, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1, 2'b00, 2'b00, 2'b00, 0}); // still h1
    tbl.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1, 2'b10, 2'b00, 2'b00, 0}); // grant h1
    tbl.push_back('{2'b01, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 0, 2'b01, 2'b00, 2'b00, 1}); // then h0
    tbl.push_back('{2'b00, 1'b0, 1'b1, 32'h11,       1'b0, 1'b0, 0, 2'b00, 2'b10, 2'b00, 2}); // route h1
    tbl.push_back('{2'b00, 1'b0, 1'b1, 32'h22,       1'b1, 1'b0, 0, 2'b00, 2'b01, 2'b01, 1}); // route h0 err

    repeat (3) @(negedge clk_sys_i);
    check("rst_out_req", 96'(bif.out_req_o), 96'(0));
    check("rst_host_gnt", 96'(bif.host_gnt_o), 96'(0));
    check("rst_host_rvalid", 96'(bif.host_rvalid_o), 96'(0));
    check("rst_outstanding", 96'(outstanding_o), 96'(0));
    rst_sys_ni = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset with two transactions outstanding and priority at host 1.
    cur_row = 100;
    apply('{2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1, 2'b10, 2'b00, 2'b00, 0});
    apply('{2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 0, 2'b01, 2'b00, 2'b00, 1});
    @(negedge clk_sys_i);
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_sys_ni = 1'b0;
    #1;
    check("midrst_outstanding", 96'(outstanding_o), 96'(0));
    check("midrst_out_req", 96'(bif.out_req_o), 96'(0));
    @(negedge clk_sys_i);
    rst_sys_ni = 1'b1;
    cur_row = 200;
    apply('{2'b00, 1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 0, 2'b00, 2'b00, 2'b00, 0}); // stray rvalid
    apply('{2'b11, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 0, 2'b01, 2'b00, 2'b00, 0}); // prio back at 0
    apply('{2'b00, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 0, 2'b00, 2'b01, 2'b00, 1});
    apply('{2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 0, 2'b00, 2'b00, 2'b00, 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
